// File: rtl/player_move_ctrl_if.sv
// Bus between the movement controller, its tile-type ROM and its consumers.
interface player_move_ctrl_if;
  logic       i_frame_tick;
  logic [7:0] i_keycode;
  logic [3:0] i_tile_type;
  logic [6:0] o_tile_index;
  logic [3:0] o_player_col;
  logic [2:0] o_player_row;
  logic [1:0] o_facing;
  logic [6:0] o_facing_index;
  logic       o_facing_valid;
  logic       o_busy;

  // Environment side: frame tick, keyboard and ROM data in; status out.
  modport master (
    output i_frame_tick, i_keycode, i_tile_type,
    input  o_tile_index, o_player_col, o_player_row, o_facing,
           o_facing_index, o_facing_valid, o_busy
  );

  // Controller side.
  modport slave (
    input  i_frame_tick, i_keycode, i_tile_type,
    output o_tile_index, o_player_col, o_player_row, o_facing,
           o_facing_index, o_facing_valid, o_busy
  );
endinterface

// File: rtl/player_move_ctrl.sv
// Grid player movement: on a frame tick, look the target tile up in the
// tile-type ROM and commit the step only onto Floor tiles.
module player_move_ctrl #(
  parameter int unsigned COLS        = 15,
  parameter int unsigned ROWS        = 8,
  parameter int unsigned START_COL   = 7,
  parameter int unsigned START_ROW   = 2,
  parameter int unsigned MOVE_PERIOD = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  player_move_ctrl_if.slave  io_bus
);

  localparam int unsigned COL_W = 4;
  localparam int unsigned ROW_W = 3;
  localparam int unsigned IDX_W = 7;
  localparam int unsigned CNT_W = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;

  localparam logic [IDX_W-1:0] IDX_OFF    = IDX_W'(127);
  localparam logic [3:0]       TYPE_FLOOR = 4'd7;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_CHECK} state_t;

  typedef struct packed {
    logic             ok;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } nbr_t;

  // Linear tile index, row-major.
  function automatic logic [IDX_W-1:0] tile_idx(input logic [COL_W-1:0] col,
                                                input logic [ROW_W-1:0] row);
    return IDX_W'(IDX_W'(row) * IDX_W'(COLS)) + IDX_W'(col);
  endfunction

  // Adjacent tile in a direction, flagged off-grid at the map edges.
  function automatic nbr_t nbr_of(input logic [COL_W-1:0] col,
                                  input logic [ROW_W-1:0] row,
                                  input logic [1:0]       dir);
    nbr_t n;
    n.ok  = 1'b1;
    n.col = col;
    n.row = row;
    case (dir)
      DIR_UP: begin
        n.ok  = (row != '0);
        n.row = row - ROW_W'(1);
      end
      DIR_DOWN: begin
        n.ok  = (32'(row) < ROWS - 1);
        n.row = row + ROW_W'(1);
      end
      DIR_LEFT: begin
        n.ok  = (col != '0);
        n.col = col - COL_W'(1);
      end
      default: begin
        n.ok  = (32'(col) < COLS - 1);
        n.col = col + COL_W'(1);
      end
    endcase
    return n;
  endfunction

  function automatic logic [IDX_W-1:0] face_idx(input nbr_t n);
    return n.ok ? tile_idx(n.col, n.row) : IDX_OFF;
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [1:0]       r_facing;
  logic [COL_W-1:0] r_tgt_col;
  logic [ROW_W-1:0] r_tgt_row;
  logic [3:0]       r_type;
  logic [IDX_W-1:0] r_tile_index;
  logic [IDX_W-1:0] r_facing_index;
  logic             r_facing_valid;
  logic             r_busy;

  logic             w_key_valid;
  logic [1:0]       w_key_dir;
  nbr_t             w_tgt;
  nbr_t             w_start_face;
  logic [COL_W-1:0] w_res_col;
  logic [ROW_W-1:0] w_res_row;
  nbr_t             w_res_face;

  // Decode the HID keycode into a direction.
  always_comb begin
    w_key_valid = 1'b1;
    w_key_dir   = DIR_UP;
    case (io_bus.i_keycode)
      8'h1A:   w_key_dir = DIR_UP;
      8'h16:   w_key_dir = DIR_DOWN;
      8'h04:   w_key_dir = DIR_LEFT;
      8'h07:   w_key_dir = DIR_RIGHT;
      default: w_key_valid = 1'b0;
    endcase
  end

  assign w_tgt        = nbr_of(r_col, r_row, w_key_dir);
  assign w_start_face = nbr_of(COL_W'(START_COL), ROW_W'(START_ROW), DIR_DOWN);

  // Position after the CHECK decision: step only onto Floor.
  assign w_res_col  = (r_type == TYPE_FLOOR) ? r_tgt_col : r_col;
  assign w_res_row  = (r_type == TYPE_FLOOR) ? r_tgt_row : r_row;
  assign w_res_face = nbr_of(w_res_col, w_res_row, r_facing);

  // Movement FSM with repeat counter; all outputs held in registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_col          <= COL_W'(START_COL);
      r_row          <= ROW_W'(START_ROW);
      r_facing       <= DIR_DOWN;
      r_tgt_col      <= COL_W'(START_COL);
      r_tgt_row      <= ROW_W'(START_ROW);
      r_type         <= '0;
      r_tile_index   <= tile_idx(COL_W'(START_COL), ROW_W'(START_ROW));
      r_facing_index <= face_idx(w_start_face);
      r_facing_valid <= w_start_face.ok;
      r_busy         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.i_frame_tick) begin
            if (!w_key_valid) begin
              r_cnt <= '0;
            end else if (r_cnt != '0) begin
              r_cnt <= r_cnt - CNT_W'(1);
            end else begin
              r_cnt     <= CNT_W'(MOVE_PERIOD - 1);
              r_facing  <= w_key_dir;
              r_tgt_col <= w_tgt.col;
              r_tgt_row <= w_tgt.row;
              if (w_tgt.ok) begin
                r_tile_index <= tile_idx(w_tgt.col, w_tgt.row);
                r_busy       <= 1'b1;
                r_state      <= S_LOOKUP;
              end else begin
                // Walking off the map: turn in place, nothing in front.
                r_facing_index <= IDX_OFF;
                r_facing_valid <= 1'b0;
              end
            end
          end
        end
        S_LOOKUP: begin
          r_type  <= io_bus.i_tile_type;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          r_col          <= w_res_col;
          r_row          <= w_res_row;
          r_facing_index <= face_idx(w_res_face);
          r_facing_valid <= w_res_face.ok;
          r_tile_index   <= tile_idx(w_res_col, w_res_row);
          r_busy         <= 1'b0;
          r_state        <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.o_tile_index   = r_tile_index;
  assign io_bus.o_player_col   = r_col;
  assign io_bus.o_player_row   = r_row;
  assign io_bus.o_facing       = r_facing;
  assign io_bus.o_facing_index = r_facing_index;
  assign io_bus.o_facing_valid = r_facing_valid;
  assign io_bus.o_busy         = r_busy;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Scoreboard bench for player_move_ctrl on a 15x8 map with a wall along row 0.
module tb_player_move_ctrl;

  localparam logic [7:0] K_W = 8'h1A;
  localparam logic [7:0] K_A = 8'h04;
  localparam logic [7:0] K_D = 8'h07;
  localparam logic [7:0] K_N = 8'h00;

  typedef struct {
    int col;
    int row;
    int face;
    int ti;
    int fi;
    int fv;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  player_move_ctrl_if bus_a ();
  player_move_ctrl_if bus_b ();

  player_move_ctrl dut_a (
    .i_clk  (clk),
    .i_reset(rst),
    .io_bus (bus_a.slave)
  );

  player_move_ctrl #(.START_COL(0), .START_ROW(1)) dut_b (
    .i_clk  (clk),
    .i_reset(rst),
    .io_bus (bus_b.slave)
  );

  // Tile ROM model: row 0 is wall (type 1), everything else Floor (7).
  function automatic logic [3:0] rom_type(input logic [6:0] idx);
    return (idx < 7'd15) ? 4'd1 : 4'd7;
  endfunction

  assign bus_a.i_tile_type = rom_type(bus_a.o_tile_index);
  assign bus_b.i_tile_type = rom_type(bus_b.o_tile_index);

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  int m_col, m_row, m_face, m_cnt, m_fi, m_fv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int m_idx(input int c, input int r);
    return r * 15 + c;
  endfunction

  function automatic void m_front(input int c, input int r, input int f,
                                  output int fi, output int fv);
    int nc, nr;
    nc = c + ((f == 2) ? -1 : (f == 3) ? 1 : 0);
    nr = r + ((f == 0) ? -1 : (f == 1) ? 1 : 0);
    if (nc < 0 || nc >= 15 || nr < 0 || nr >= 8) begin
      fi = 127;
      fv = 0;
    end else begin
      fi = m_idx(nc, nr);
      fv = 1;
    end
  endfunction

  task automatic m_reset();
    m_col  = 7;
    m_row  = 2;
    m_face = 1;
    m_cnt  = 0;
    m_front(m_col, m_row, m_face, m_fi, m_fv);
    sb.delete();
  endtask

  // Reference step for one accepted tick; pushes the expected end state.
  task automatic model_step(input logic [7:0] key, output bit mv, output int tgt);
    int   dir, nc, nr;
    exp_t e;
    mv  = 1'b0;
    tgt = 0;
    case (key)
      K_W:     dir = 0;
      8'h16:   dir = 1;
      K_A:     dir = 2;
      K_D:     dir = 3;
      default: dir = -1;
    endcase
    if (dir < 0) begin
      m_cnt = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
    end else begin
      m_cnt  = 7;
      m_face = dir;
      nc = m_col + ((dir == 2) ? -1 : (dir == 3) ? 1 : 0);
      nr = m_row + ((dir == 0) ? -1 : (dir == 1) ? 1 : 0);
      if (nc < 0 || nc >= 15 || nr < 0 || nr >= 8) begin
        m_fi = 127;
        m_fv = 0;
      end else begin
        mv  = 1'b1;
        tgt = m_idx(nc, nr);
        if (rom_type(7'(tgt)) == 4'd7) begin
          m_col = nc;
          m_row = nr;
        end
        m_front(m_col, m_row, m_face, m_fi, m_fv);
      end
    end
    e.col  = m_col;
    e.row  = m_row;
    e.face = m_face;
    e.ti   = m_idx(m_col, m_row);
    e.fi   = m_fi;
    e.fv   = m_fv;
    sb.push_back(e);
  endtask

  task automatic compare_pop();
    exp_t e;
    chk("sb_depth", 32'(sb.size()), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("col",        32'(bus_a.o_player_col),   e.col);
      chk("row",        32'(bus_a.o_player_row),   e.row);
      chk("facing",     32'(bus_a.o_facing),       e.face);
      chk("tile_index", 32'(bus_a.o_tile_index),   e.ti);
      chk("face_index", 32'(bus_a.o_facing_index), e.fi);
      chk("face_valid", 32'(bus_a.o_facing_valid), e.fv);
      chk("busy_done",  32'(bus_a.o_busy),         0);
    end
  endtask

  // One frame tick on dut_a; dbl re-pulses the tick during the LOOKUP cycle.
  task automatic run_tick(input logic [7:0] key, input bit dbl);
    bit mv;
    int tgt;
    model_step(key, mv, tgt);
    @(negedge clk);
    bus_a.i_keycode    = key;
    bus_a.i_frame_tick = 1'b1;
    @(negedge clk);
    bus_a.i_frame_tick = dbl;
    if (mv) begin
      chk("busy_T",      32'(bus_a.o_busy),       1);
      chk("tidx_lookup", 32'(bus_a.o_tile_index), 32'(tgt));
      chk("facing_T",    32'(bus_a.o_facing),     32'(sb[$].face));
      @(negedge clk);
      bus_a.i_frame_tick = 1'b0;
      chk("busy_T1",     32'(bus_a.o_busy),       1);
      chk("tidx_T1",     32'(bus_a.o_tile_index), 32'(tgt));
      @(negedge clk);
    end
    bus_a.i_frame_tick = 1'b0;
    compare_pop();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus_a.i_frame_tick = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  initial begin
    rst                = 1'b1;
    bus_a.i_frame_tick = 1'b0;
    bus_a.i_keycode    = K_N;
    bus_b.i_frame_tick = 1'b0;
    bus_b.i_keycode    = K_N;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_reset();

    // Reset values with default and shifted start positions.
    chk("rst_col",  32'(bus_a.o_player_col),   7);
    chk("rst_row",  32'(bus_a.o_player_row),   2);
    chk("rst_face", 32'(bus_a.o_facing),       1);
    chk("rst_ti",   32'(bus_a.o_tile_index),   37);
    chk("rst_fi",   32'(bus_a.o_facing_index), 52);
    chk("rst_fv",   32'(bus_a.o_facing_valid), 1);
    chk("rst_busy", 32'(bus_a.o_busy),         0);
    chk("b_rst_ti", 32'(bus_b.o_tile_index),   15);
    chk("b_rst_fi", 32'(bus_b.o_facing_index), 30);

    // D moves right; holding repeats after exactly 8 ticks.
    run_tick(K_D, 1'b0);
    chk("d_col", 32'(bus_a.o_player_col),   8);
    chk("d_fi",  32'(bus_a.o_facing_index), 39);
    for (int i = 0; i < 7; i++) run_tick(K_D, 1'b0);
    chk("hold_wait_col", 32'(bus_a.o_player_col), 8);
    run_tick(K_D, 1'b0);
    chk("hold_move_col", 32'(bus_a.o_player_col), 9);

    // W twice with a release: second attempt hits the wall at index 7.
    do_reset();
    run_tick(K_W, 1'b0);
    chk("w1_row", 32'(bus_a.o_player_row), 1);
    run_tick(K_N, 1'b0);
    run_tick(K_W, 1'b0);
    chk("w2_row",  32'(bus_a.o_player_row),   1);
    chk("w2_face", 32'(bus_a.o_facing),       0);
    chk("w2_fi",   32'(bus_a.o_facing_index), 7);

    // Reset while in LOOKUP returns to start with a cleared counter.
    do_reset();
    @(negedge clk);
    bus_a.i_keycode    = K_D;
    bus_a.i_frame_tick = 1'b1;
    @(negedge clk);
    bus_a.i_frame_tick = 1'b0;
    chk("lk_busy", 32'(bus_a.o_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("lkr_busy", 32'(bus_a.o_busy),       0);
    chk("lkr_col",  32'(bus_a.o_player_col), 7);
    chk("lkr_row",  32'(bus_a.o_player_row), 2);
    chk("lkr_face", 32'(bus_a.o_facing),     1);
    chk("lkr_ti",   32'(bus_a.o_tile_index), 37);
    m_reset();
    run_tick(K_D, 1'b0);
    chk("lkr_move_col", 32'(bus_a.o_player_col), 8);

    // A tick during LOOKUP is dropped: one move, counter untouched by it.
    do_reset();
    run_tick(K_D, 1'b1);
    chk("drop_col", 32'(bus_a.o_player_col), 8);
    for (int i = 0; i < 7; i++) run_tick(K_D, 1'b0);
    chk("drop_wait_col", 32'(bus_a.o_player_col), 8);
    run_tick(K_D, 1'b0);
    chk("drop_move_col", 32'(bus_a.o_player_col), 9);

    // Off-grid left from column 0 turns in place without a lookup.
    @(negedge clk);
    bus_b.i_keycode    = K_A;
    bus_b.i_frame_tick = 1'b1;
    @(negedge clk);
    bus_b.i_frame_tick = 1'b0;
    chk("off_face", 32'(bus_b.o_facing),       2);
    chk("off_fi",   32'(bus_b.o_facing_index), 127);
    chk("off_fv",   32'(bus_b.o_facing_valid), 0);
    chk("off_busy", 32'(bus_b.o_busy),         0);
    chk("off_col",  32'(bus_b.o_player_col),   0);
    chk("off_ti",   32'(bus_b.o_tile_index),   15);
    @(negedge clk);
    chk("off_busy2", 32'(bus_b.o_busy),       0);
    chk("off_col2",  32'(bus_b.o_player_col), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/player_move_ctrl.md
# player_move_ctrl

Grid-based player movement controller for the kitchen map. On each frame tick it reads the WASD keycode, computes the tile the player is trying to enter, looks that tile up in the tile-type ROM and commits the move only if the tile is Floor. It sits directly upstream of the tile-type ROM: it drives the 7-bit tile index and consumes the 4-bit tile type. It also publishes the player's tile position, facing direction and faced-tile index to the interaction and sprite logic.

## Interface
- COLS, 15: map width in tiles.
- ROWS, 8: map height in tiles.
- START_COL, 7: column after reset.
- START_ROW, 2: row after reset.
- MOVE_PERIOD, 8: frame ticks between repeated moves while a key is held (≥1).
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame (vsync-derived).
- keycode  in  8  USB HID keycode: W=0x1A, A=0x04, S=0x16, D=0x07; any other value means no direction.
- tile_type  in  4  tile-type ROM output for tile_index (combinational, same cycle). Floor=7.
- tile_index  out  7  index to the tile-type ROM, row*COLS+col.
- player_col  out  4  current column.
- player_row  out  3  current row.
- facing  out  2  0=up, 1=down, 2=left, 3=right.
- facing_index  out  7  index of the tile in front of the player; 127 if off-grid.
- facing_valid  out  1  facing tile is on-grid.
- busy  out  1  lookup in progress.

## Operation
- States: IDLE, LOOKUP, CHECK.
- IDLE:
  - tile_index = current position index.
  - frame_tick is acted on only in IDLE. A frame_tick that arrives in LOOKUP or CHECK is dropped.
- On frame_tick in IDLE, using the repeat counter cnt:
  - No direction key: cnt←0, no move.
  - Direction key and cnt≠0: cnt←cnt−1, no move.
  - Direction key and cnt==0: cnt←MOVE_PERIOD−1. Facing is updated immediately and the target tile is latched.
    - Target off-grid (row<0, row≥ROWS, col<0, col≥COLS): stay in IDLE. Position unchanged, facing_index=127, facing_valid=0.
    - Target on-grid: tile_index←target index, go to LOOKUP.
- LOOKUP: register tile_type, go to CHECK.
- CHECK:
  - Registered type == 7: position←target.
  - Otherwise: position unchanged (blocked).
  - Either way: recompute facing_index/facing_valid from the resulting position and facing; tile_index←resulting position index; go to IDLE.
- Index arithmetic is row*15 computed as (row<<4)−row, plus col, in 7 bits. The maximum is 119, so there is no overflow.
- Direction key priority when the keycode is decoded: only a single keycode byte exists, so no conflicts are possible.
- Reset, from any state, next edge:
  - state=IDLE, cnt=0, busy=0.
  - player_col=START_COL, player_row=START_ROW, facing=1.
  - tile_index=START_ROW*COLS+START_COL.
  - facing_index = index of the tile below the start, or 127 with facing_valid=0 if that tile is off-grid.
  - With defaults: tile_index=37, facing_index=52, facing_valid=1.

## Timing
- All outputs are registered.
- frame_tick sampled at edge T:
  - Facing updated at T.
  - tile_index = target from T, through LOOKUP.
  - tile_type sampled at T+1.
  - player_col/row and facing_index updated at T+2.
  - busy high from T to T+2, low after T+2.
- Total move latency: 3 edges after the tick.
- An off-grid attempt completes at T with busy never asserted.
- Held key: moves occur on ticks 0, MOVE_PERIOD, 2·MOVE_PERIOD, …
- Releasing the key for one tick clears cnt, so the next press moves on its first tick.

## Test plan
- Reset with defaults: col=7, row=2, facing=1, tile_index=37, facing_index=52, facing_valid=1, busy=0.
- keycode=0x07, one tick:
  - tile_index=38 during LOOKUP, busy for 3 edges.
  - Afterwards col=8, facing=3, facing_index=39.
  - Keep holding: the next move occurs exactly 8 ticks later (col=9).
- From (7,2), W pressed twice with a release in between:
  - First press moves to row=1.
  - Second press targets index 7 (type 1), so the move is blocked: row stays 1, facing=0, facing_index=7.
- START_COL=0, START_ROW=1, keycode=0x04:
  - facing=2, facing_index=127, facing_valid=0.
  - busy stays 0; col=0.
- Reset asserted in LOOKUP: next edge state IDLE, busy=0, position (7,2), facing=1, cnt=0. A following D tick moves immediately.
- frame_tick pulsed in the LOOKUP cycle: the tick is ignored, exactly one move occurs, and cnt decrements only once.
